// File: rtl/sc_et_sng_ctrl.sv
// Run controller for an LFSR SNG with progressive-precision early termination.
// Optional SC_ET_STATS_EN adds cycles_saved / runs_done statistics outputs.
module sc_et_sng_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned OUT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] len,
   input  logic [WIDTH-1:0] thr,
   output logic             busy,
   output logic             sng_load,
   output logic             sng_en,
   input  logic             bit_in,
   input  logic             bit_vld,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             result,
   output logic [WIDTH-1:0] ones_cnt,
   output logic [WIDTH-1:0] used_cnt
`ifdef SC_ET_STATS_EN
   ,
   output logic [31:0]      cycles_saved,
   output logic [31:0]      runs_done
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [OUT_W-1:0] OUT_MAX = '1;

   state_e           state_q;
   logic [WIDTH-1:0] len_q, thr_q;
   logic [WIDTH-1:0] ones_q, rcv_q, iss_q;
   logic [OUT_W-1:0] out_q, out_d;
   logic             busy_q, load_q, valid_q, res_q;
   logic [WIDTH-1:0] ones_cnt_q, used_cnt_q;

   logic             dec_hi, dec_lo, decided, acc;
   logic [WIDTH:0]   best;

   // Best reachable count if every remaining bit were a 1.
   assign best    = {1'b0, ones_q} + {1'b0, len_q} - {1'b0, rcv_q};
   assign dec_hi  = ones_q >= thr_q;
   assign dec_lo  = best < {1'b0, thr_q};
   assign decided = dec_hi | dec_lo;

   assign sng_en = (state_q == S_RUN) && !decided &&
                   (iss_q < len_q) && (out_q != OUT_MAX);

   // A zero-latency datapath returns its bit alongside the issuing cycle.
   assign acc   = bit_vld && ((out_q != '0) || sng_en);
   assign out_d = out_q + OUT_W'(sng_en) - OUT_W'(acc);

`ifdef SC_ET_STATS_EN
   logic [31:0] saved_q, runs_q;
   logic [32:0] saved_sum;

   assign saved_sum    = {1'b0, saved_q} + 33'(len_q - rcv_q);
   assign cycles_saved = saved_q;
   assign runs_done    = runs_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         thr_q      <= '0;
         ones_q     <= '0;
         rcv_q      <= '0;
         iss_q      <= '0;
         out_q      <= '0;
         busy_q     <= 1'b0;
         load_q     <= 1'b0;
         valid_q    <= 1'b0;
         res_q      <= 1'b0;
         ones_cnt_q <= '0;
         used_cnt_q <= '0;
`ifdef SC_ET_STATS_EN
         saved_q    <= '0;
         runs_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q   <= len;
                  thr_q   <= thr;
                  ones_q  <= '0;
                  rcv_q   <= '0;
                  iss_q   <= '0;
                  out_q   <= '0;
                  busy_q  <= 1'b1;
                  load_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               load_q  <= 1'b0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               out_q <= out_d;
               if (decided) begin
                  res_q      <= dec_hi;
                  ones_cnt_q <= ones_q;
                  used_cnt_q <= rcv_q;
                  state_q    <= S_DRAIN;
`ifdef SC_ET_STATS_EN
                  saved_q <= saved_sum[32] ? '1 : saved_sum[31:0];
`endif
               end else begin
                  iss_q <= iss_q + WIDTH'(sng_en);
                  if (acc) begin
                     rcv_q  <= rcv_q + 1'b1;
                     ones_q <= ones_q + WIDTH'(bit_in);
                  end
               end
            end
            S_DRAIN: begin
               out_q <= out_d;
               if (out_q == '0) begin
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_DONE;
`ifdef SC_ET_STATS_EN
                  runs_q <= (runs_q == '1) ? runs_q : runs_q + 1'b1;
`endif
               end
            end
            S_DONE: begin
               if (result_ack) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign sng_load     = load_q;
   assign result_valid = valid_q;
   assign result       = res_q;
   assign ones_cnt     = ones_cnt_q;
   assign used_cnt     = used_cnt_q;

endmodule

// File: doc/sc_et_sng_ctrl.md
Name: sc_et_sng_ctrl

Overview:
Run controller for one LFSR-based stochastic number generator (SNG) feeding a stochastic-computing datapath.
- Sequences each run: reloads the SNG seed, enables the SNG for up to `len` cycles, and counts the 1s returned by the datapath.
- Applies progressive-precision early termination against a threshold: stops as soon as the outcome `ones >= thr` can no longer change.
- Drains in-flight bits, then presents the result with a valid/ack handshake.

Parameters:
- WIDTH, 8, SNG/LFSR width; `len`, `thr` and the counters are WIDTH bits (max stream length 2^WIDTH-1).
- OUT_W, 3, width of the outstanding-bit counter; the datapath may hold at most 2^OUT_W-1 bits in flight.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  run request; accepted only in IDLE
- len  in  WIDTH  stream length for the run, sampled on start accept
- thr  in  WIDTH  decision threshold, sampled on start accept
- busy  out  1  high in LOAD, RUN, DRAIN
- sng_load  out  1  one-cycle pulse; SNG reloads its start state
- sng_en  out  1  SNG advance enable; one issued bit per high cycle
- bit_in  in  1  datapath output bit
- bit_vld  in  1  bit_in valid; arrives a fixed latency after the corresponding sng_en
- result_valid  out  1  result available; held until acked
- result_ack  in  1  consumes result
- result  out  1  decision: 1 iff ones >= thr
- ones_cnt  out  WIDTH  1s counted up to the decision
- used_cnt  out  WIDTH  bits counted up to the decision

Behaviour:
Reset (sync, rst=1):
- State = IDLE; all outputs 0; all internal counters 0.
- Reset mid-run abandons the run with no result. The SNG is reseeded by the next LOAD.

States:
- IDLE:
  - If start=1: latch len/thr, clear counters (ones, rcv, issued), go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - sng_load=1 for exactly one cycle, sng_en=0, then go to RUN.
- RUN:
  - Evaluate on the registered counters each cycle:
    - decided_hi = ones >= thr
    - decided_lo = ones + (len - rcv) < thr, computed at WIDTH+1 bits
  - sng_en = !decided_hi && !decided_lo && (issued < len) && (outstanding < 2^OUT_W-1), where outstanding = issued - rcv.
  - If decided_hi or decided_lo: latch result (= decided_hi), ones_cnt and used_cnt (= rcv), then go to DRAIN. This happens in the same cycle sng_en=0.
- DRAIN:
  - sng_en=0.
  - Bits arriving with bit_vld are not counted in ones/rcv, but they do decrement outstanding.
  - When outstanding == 0, go to DONE.
- DONE:
  - result_valid=1, outputs stable.
  - If result_ack=1: result_valid drops next cycle, go to IDLE.
  - A start that arrives in the same cycle as the ack is ignored.

Counting:
- In RUN, each bit_vld=1 gives rcv += 1 and ones += bit_in.
- sng_en=1 gives issued += 1.
- Both update at the same edge; simultaneous issue and receive leave outstanding unchanged.

Boundary cases:
- Decision always resolves by rcv == len, because then remaining = 0 and exactly one of the two conditions holds.
- thr=0: decided_hi on the first RUN cycle; result=1, used_cnt=0, sng_en never high.
- len=0 with thr>0: decided_lo immediately; result=0.
- bit_vld arriving with outstanding == 0 is a protocol error and is ignored.

Latency:
- start accepted at cycle 0; sng_load in cycle 1; first possible sng_en in cycle 2.

Optional Feature:
Macro: SC_ET_STATS_EN
- Defined:
  - Adds output cycles_saved (32 bits). On each decision it accumulates (len - used_cnt), saturating at 2^32-1.
  - Adds output runs_done (32 bits). It increments on each DONE entry, saturating.
  - Both clear only on rst.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. WIDTH=8, datapath latency 0, len=255, thr=128, bit_in=1 every cycle -> exactly 128 sng_en pulses; result=1, ones_cnt=128, used_cnt=128; result_valid held until result_ack.
2. len=255, thr=128, bit_in=0 -> decided_lo once rcv=128; result=0, ones_cnt=0, used_cnt=128.
3. thr=0, len=255 -> sng_load pulse, no sng_en; result=1, used_cnt=0. Separately, len=100, thr=200 -> result=0, used_cnt=0, no sng_en.
4. Datapath latency 3, len=255, thr=10, bit_in=1:
   - outstanding never exceeds 7;
   - decision at used_cnt=10;
   - 3 extra bits drained and not counted, ones_cnt=10;
   - DONE entered only after the last bit_vld.
5. rst asserted mid-RUN (rcv=50) -> next cycle: IDLE, all outputs 0. A new start replays from sng_load with counters at 0.
6. With SC_ET_STATS_EN, run scenario 1 then scenario 2 -> cycles_saved=254, runs_done=2. start during DONE is ignored; result_ack returns to IDLE.
